usr_param: RTL and testbench
============================

# usr_param

Parametrised universal shift register, successor to the fixed 4-bit hold/shift/load register. Adds a configurable width, serial fill inputs, rotate, arithmetic shift and clear operations, and multi-bit shift amounts. Commands arrive over a valid/ready handshake. Shifts execute one bit per cycle under a small state machine, or in a single cycle when the barrel option is compiled in.

## Interface
- WIDTH, 8, register width in bits (≥2)
- SHW, $clog2(WIDTH+1), width of the shift-amount field (derived; not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  command present
- op_ready  out  1  block can accept a command; equals (state==IDLE)
- op  in  3  000 NOP, 001 SHR, 010 SHL, 011 LOAD, 100 ROR, 101 ROL, 110 ASR, 111 CLR
- shamt  in  SHW  shift/rotate amount, used by shift ops only
- d  in  WIDTH  parallel load data
- sin_l  in  1  serial fill into MSB on SHR
- sin_r  in  1  serial fill into LSB on SHL
- q  out  WIDTH  register contents
- busy  out  1  multi-cycle shift in progress
- done  out  1  one-cycle pulse after the final q update of a command

## Operation
- Accept occurs on the edge where op_valid && op_ready. The command is not otherwise sampled, and op_valid while busy is ignored.
- NOP: q unchanged. LOAD: q←d. CLR: q←0. Each completes at the accept edge.
- One shift step per operation:
  - SHR: q←{sin_l, q[W-1:1]}
  - SHL: q←{q[W-2:0], sin_r}
  - ROR: q←{q[0], q[W-1:1]}
  - ROL: q←{q[W-2:0], q[W-1]}
  - ASR: q←{q[W-1], q[W-1:1]}
- Shift ops use effective amount N = min(shamt, WIDTH).
- N=0: q unchanged, treated like NOP.
- Serial inputs are sampled live at each step edge, not latched at accept.
- ROR/ROL with N=WIDTH returns q to its original value. SHR/SHL with N=WIDTH fills q entirely with serial bits. ASR with N=WIDTH gives all bits equal to the original MSB.
- FSM states are IDLE and SHIFT, with a down-counter cnt of SHW bits:
  - IDLE, accept shift op with N≥2: apply one step, cnt←N-1, go to SHIFT.
  - IDLE, accept any other op (including N≤1): apply the op, stay in IDLE, done←1 next cycle.
  - SHIFT: apply one step, cnt←cnt-1. On the edge where cnt==1, return to IDLE and set done←1.
- done is registered and high for exactly one cycle per accepted command, including NOP.

## Timing
- Reset values: q=0, state=IDLE, cnt=0, done=0, busy=0, op_ready=1.
- Asserting reset mid-shift aborts the command immediately: q=0, no done pulse.
- Shift with N≥2: N step edges total, busy and !op_ready for N-1 cycles after accept, done in the cycle after the last step.
- Single-edge commands: done in the cycle after accept, op_ready stays 1. This allows back-to-back accepts every cycle.
- A new command may be accepted in the same cycle that done is high.

## Configuration
- USR_BARREL_EN defined:
  - Every shift op completes at the accept edge using an N-position barrel shift.
  - SHR/SHL fill all N vacated bits with the sin_l/sin_r value sampled at that edge.
  - The SHIFT state is never entered, busy is constant 0, and op_ready is constant 1. done follows the single-edge rule.
- USR_BARREL_EN undefined: bit-serial FSM as described above.
- Final q is identical in both builds when the serial inputs are held constant.

## Structure
- Package usr_pkg holds:
  - the op enum (encodings above)
  - the FSM state enum (IDLE, SHIFT)
  - a localparam for the NOP/LOAD/CLR/shift class decode
- Sub-module usr_step_unit (combinational): given q, op, sin_l and sin_r, returns the one-step next value. It is instantiated once in the bit-serial build. The barrel build uses a separate shift function in the top module.

## Test plan
- Reset low then release, WIDTH=8 → q=0x00, op_ready=1, busy=0, done=0.
- LOAD d=0xA5 → q=0xA5 after the accept edge; done high exactly 1 cycle; op_ready never drops.
- From q=0xA5: SHR shamt=3, sin_l=1 → q steps 0xD2, 0xE9, 0xF4; busy=1 for 2 cycles; one done pulse. A second op_valid during busy is ignored.
- From q=0x3C: ROL shamt=8 → q=0x3C after 8 steps. Repeat with shamt=12: clamped, same 8 cycles, same result.
- From q=0x90: ASR shamt=2 → q=0xE4. shamt=0 → q unchanged, done next cycle.
- SHL shamt=5 with reset asserted after 2 steps → q=0x00 asynchronously, busy=0, no done; the next LOAD is accepted normally.

Source files
------------

// File: rtl/usr_pkg.sv
// usr_pkg: shared definitions for the universal shift register.
// Holds the command encodings, the FSM state encoding and the op-class decode.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit k set means op encoding k is a shift/rotate that honours shamt.
  // NOP, LOAD and CLR are single-edge commands that ignore shamt.
  localparam logic [7:0] OP_SHIFT_MASK = 8'b0111_0110;

  function automatic logic op_is_shift(input logic [2:0] op);
    return OP_SHIFT_MASK[op];
  endfunction

endpackage

// File: rtl/usr_if.sv
// usr_if: command/result bundle of the universal shift register.
// master drives commands (bench or upstream logic), slave is the register.
interface usr_if #(
  parameter int WIDTH = 8
) ();
  localparam int SHW = $clog2(WIDTH + 1);

  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output op_valid, op, shamt, d, sin_l, sin_r,
    input  op_ready, q, busy, done
  );

  modport slave (
    input  op_valid, op, shamt, d, sin_l, sin_r,
    output op_ready, q, busy, done
  );

endinterface

// File: rtl/usr_step_unit.sv
// usr_step_unit: combinational single-position step of the shift register.
// Non-shift ops pass q through unchanged.
module usr_step_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       op_i,
  input  logic             sin_l_i,
  input  logic             sin_r_i,
  output logic [WIDTH-1:0] q_o
);

  // One step of the selected shift/rotate; serial fills come in live.
  always_comb begin
    q_o = q_i;
    case (op_i)
      OP_SHR:  q_o = {sin_l_i, q_i[WIDTH-1:1]};
      OP_SHL:  q_o = {q_i[WIDTH-2:0], sin_r_i};
      OP_ROR:  q_o = {q_i[0], q_i[WIDTH-1:1]};
      OP_ROL:  q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      OP_ASR:  q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      default: q_o = q_i;
    endcase
  end

endmodule

// File: rtl/usr_param.sv
// usr_param: parametrised universal shift register with valid/ready commands.
// Build option: define USR_BARREL_EN for single-edge N-position barrel shifts;
// default build steps one bit per cycle under a two-state FSM.
module usr_param
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  usr_if.slave bus
);

  localparam int SHW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic             ready;
  logic             accept;
  logic             is_shift;
  logic [SHW-1:0]   n_eff;

  // Amounts beyond the register width behave exactly like WIDTH.
  assign n_eff    = (bus.shamt > SHW'(WIDTH)) ? SHW'(WIDTH) : bus.shamt;
  assign is_shift = op_is_shift(bus.op);
  assign accept   = bus.op_valid && ready;

  assign bus.q        = q_q;
  assign bus.done     = done_q;
  assign bus.op_ready = ready;

`ifdef USR_BARREL_EN

  function automatic logic [WIDTH-1:0] barrel_shift(
    input logic [WIDTH-1:0] v,
    input logic [2:0]       op,
    input logic [SHW-1:0]   n,
    input logic             sl,
    input logic             sr
  );
    logic [2*WIDTH-1:0] wide;
    logic [WIDTH-1:0]   res;
    wide = '0;
    res  = v;
    case (op)
      OP_SHR: begin
        wide = {{WIDTH{sl}}, v} >> n;
        res  = wide[WIDTH-1:0];
      end
      OP_SHL: begin
        wide = {v, {WIDTH{sr}}} << n;
        res  = wide[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        wide = {v, v} >> n;
        res  = wide[WIDTH-1:0];
      end
      OP_ROL: begin
        wide = {v, v} << n;
        res  = wide[2*WIDTH-1:WIDTH];
      end
      OP_ASR: begin
        wide = {{WIDTH{v[WIDTH-1]}}, v} >> n;
        res  = wide[WIDTH-1:0];
      end
      default: res = v;
    endcase
    return res;
  endfunction

  assign ready    = 1'b1;
  assign bus.busy = 1'b0;

  // Every command, shifts included, resolves at its accept edge.
  always_comb begin
    q_d    = q_q;
    done_d = 1'b0;
    if (accept) begin
      done_d = 1'b1;
      if (is_shift) begin
        q_d = barrel_shift(q_q, bus.op, n_eff, bus.sin_l, bus.sin_r);
      end else if (bus.op == OP_LOAD) begin
        q_d = bus.d;
      end else if (bus.op == OP_CLR) begin
        q_d = '0;
      end
    end
  end

`else

  localparam logic [0:0] S_IDLE  = ST_IDLE;
  localparam logic [0:0] S_SHIFT = ST_SHIFT;

  logic [0:0]       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_q;

  assign ready    = (state_q == S_IDLE);
  assign bus.busy = (state_q == S_SHIFT);

  // While idle the step unit sees the incoming op; afterwards the held one.
  assign step_op = ready ? bus.op : op_q;

  usr_step_unit #(
    .WIDTH (WIDTH)
  ) u_step (
    .q_i     (q_q),
    .op_i    (step_op),
    .sin_l_i (bus.sin_l),
    .sin_r_i (bus.sin_r),
    .q_o     (step_q)
  );

  // Next-state: accept in IDLE, one step per cycle in SHIFT until cnt hits 1.
  always_comb begin
    q_d     = q_q;
    done_d  = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (state_q == S_IDLE) begin
      if (accept) begin
        done_d = 1'b1;
        if (is_shift) begin
          if (n_eff != '0) begin
            q_d = step_q;
          end
          if (n_eff >= SHW'(2)) begin
            state_d = S_SHIFT;
            cnt_d   = n_eff - SHW'(1);
            op_d    = bus.op;
            done_d  = 1'b0;
          end
        end else if (bus.op == OP_LOAD) begin
          q_d = bus.d;
        end else if (bus.op == OP_CLR) begin
          q_d = '0;
        end
      end
    end else begin
      q_d   = step_q;
      cnt_d = cnt_q - SHW'(1);
      if (cnt_q == SHW'(1)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // FSM state and remaining-step counter; reset aborts any shift in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held op of the shift in progress; only meaningful while in SHIFT.
  always_ff @(posedge clk) begin
    op_q <= op_d;
  end

`endif

  // Register contents and the one-cycle completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_usr_param.sv
// tb_usr_param: self-checking bench for usr_param (WIDTH=8, bit-serial build).
module tb_usr_param;

  localparam int W = 8;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_SHR  = 3'd1;
  localparam logic [2:0] C_SHL  = 3'd2;
  localparam logic [2:0] C_LOAD = 3'd3;
  localparam logic [2:0] C_ROR  = 3'd4;
  localparam logic [2:0] C_ROL  = 3'd5;
  localparam logic [2:0] C_ASR  = 3'd6;
  localparam logic [2:0] C_CLR  = 3'd7;

  typedef struct {
    logic [2:0] op;
    logic [3:0] shamt;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] exp_q;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [7:0] mq;
  vec_t tbl [12];

  usr_if #(.WIDTH(W)) bif ();

  usr_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [3:0] sh,
                       input logic [7:0] dd, input logic sl, input logic sr);
    bif.op_valid = v;
    bif.op       = o;
    bif.shamt    = sh;
    bif.d        = dd;
    bif.sin_l    = sl;
    bif.sin_r    = sr;
  endtask

  // Spec-level single step written as plain integer arithmetic on the value.
  function automatic logic [7:0] ref_step(input logic [7:0] v, input logic [2:0] o,
                                          input logic sl, input logic sr);
    int x;
    int r;
    x = int'(v);
    case (o)
      C_SHR:   r = x / 2 + (sl ? 128 : 0);
      C_SHL:   r = (x * 2 + (sr ? 1 : 0)) % 256;
      C_ROR:   r = x / 2 + (x % 2) * 128;
      C_ROL:   r = (x * 2) % 256 + x / 128;
      C_ASR:   r = x / 2 + (x >= 128 ? 128 : 0);
      default: r = x;
    endcase
    return 8'(r);
  endfunction

  // Issue one command, then run until busy drops (bounded).
  task automatic run_cmd(input logic [2:0] o, input logic [3:0] sh, input logic sl,
                         input logic sr, output int busy_cyc, output int done_early);
    int guard;
    drive(1'b1, o, sh, 8'h00, sl, sr);
    tick();
    bif.op_valid = 1'b0;
    busy_cyc   = 0;
    done_early = 0;
    guard      = 0;
    while (bif.busy === 1'b1 && guard < 20) begin
      busy_cyc++;
      if (bif.done !== 1'b0) done_early++;
      tick();
      guard++;
    end
  endtask

  task automatic load(input logic [7:0] v);
    drive(1'b1, C_LOAD, 4'd0, v, 1'b0, 1'b0);
    tick();
    bif.op_valid = 1'b0;
  endtask

  // Random command stream compared cycle by cycle against a command-level model.
  task automatic random_phase();
    logic [7:0] expq [8];
    logic       sl [8];
    logic       sr [8];
    logic [2:0] o;
    logic [3:0] sh;
    logic [7:0] dd;
    int         n, edges, gap;
    bit         is_sh;
    for (int c = 0; c < 80; c++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        tick();
        check("rnd idle q", 32'(bif.q), 32'(mq));
        check("rnd idle done", 32'(bif.done), 32'(0));
        check("rnd idle busy", 32'(bif.busy), 32'(0));
      end
      o  = 3'($urandom_range(0, 7));
      sh = 4'($urandom_range(0, 15));
      dd = 8'($urandom_range(0, 255));
      n  = (int'(sh) > W) ? W : int'(sh);
      is_sh = (o == C_SHR) || (o == C_SHL) || (o == C_ROR) || (o == C_ROL) || (o == C_ASR);
      edges = (is_sh && n >= 2) ? n : 1;
      for (int e = 0; e < edges; e++) begin
        sl[e] = 1'($urandom_range(0, 1));
        sr[e] = 1'($urandom_range(0, 1));
        if (is_sh && n > 0) mq = ref_step(mq, o, sl[e], sr[e]);
        else if (o == C_LOAD) mq = dd;
        else if (o == C_CLR) mq = 8'h00;
        expq[e] = mq;
      end
      for (int e = 0; e < edges; e++) begin
        if (e == 0) drive(1'b1, o, sh, dd, sl[e], sr[e]);
        else drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                   8'($urandom_range(0, 255)), sl[e], sr[e]);
        tick();
        check($sformatf("rnd c%0d e%0d q", c, e), 32'(bif.q), 32'(expq[e]));
        check($sformatf("rnd c%0d e%0d busy", c, e), 32'(bif.busy), 32'(e < edges - 1));
        check($sformatf("rnd c%0d e%0d ready", c, e), 32'(bif.op_ready), 32'(e == edges - 1));
        check($sformatf("rnd c%0d e%0d done", c, e), 32'(bif.done), 32'(e == edges - 1));
      end
    end
    bif.op_valid = 1'b0;
  endtask

  initial begin
    int bc, de;

    tbl[0]  = '{C_LOAD, 4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5};
    tbl[1]  = '{C_NOP,  4'd3, 8'h11, 1'b1, 1'b1, 8'hA5};
    tbl[2]  = '{C_SHR,  4'd1, 8'h00, 1'b1, 1'b0, 8'hD2};
    tbl[3]  = '{C_SHL,  4'd1, 8'h00, 1'b0, 1'b1, 8'hA5};
    tbl[4]  = '{C_ROR,  4'd1, 8'h00, 1'b0, 1'b0, 8'hD2};
    tbl[5]  = '{C_ROL,  4'd1, 8'h00, 1'b0, 1'b0, 8'hA5};
    tbl[6]  = '{C_ASR,  4'd1, 8'h00, 1'b0, 1'b0, 8'hD2};
    tbl[7]  = '{C_SHR,  4'd0, 8'h00, 1'b1, 1'b1, 8'hD2};
    tbl[8]  = '{C_CLR,  4'd5, 8'hFF, 1'b1, 1'b1, 8'h00};
    tbl[9]  = '{C_LOAD, 4'd0, 8'h3C, 1'b0, 1'b0, 8'h3C};
    tbl[10] = '{C_SHL,  4'd1, 8'h00, 1'b1, 1'b0, 8'h78};
    tbl[11] = '{C_ASR,  4'd0, 8'h00, 1'b0, 1'b0, 8'h78};

    reset = 1'b0;
    drive(1'b0, C_NOP, 4'd0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset q", 32'(bif.q), 32'h00);
    check("reset ready", 32'(bif.op_ready), 32'(1));
    check("reset busy", 32'(bif.busy), 32'(0));
    check("reset done", 32'(bif.done), 32'(0));
    reset = 1'b1;
    tick();
    check("post-reset q", 32'(bif.q), 32'h00);
    check("post-reset done", 32'(bif.done), 32'(0));

    // Back-to-back single-edge commands.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].shamt, tbl[i].d, tbl[i].sl, tbl[i].sr);
      tick();
      check($sformatf("tbl%0d q", i), 32'(bif.q), 32'(tbl[i].exp_q));
      check($sformatf("tbl%0d done", i), 32'(bif.done), 32'(1));
      check($sformatf("tbl%0d ready", i), 32'(bif.op_ready), 32'(1));
    end
    bif.op_valid = 1'b0;
    tick();
    check("tbl idle done", 32'(bif.done), 32'(0));
    check("tbl idle q", 32'(bif.q), 32'h78);

    // SHR by 3 with sin_l=1, extra command offered while busy.
    load(8'hA5);
    check("seqA load q", 32'(bif.q), 32'hA5);
    drive(1'b1, C_SHR, 4'd3, 8'h00, 1'b1, 1'b0);
    tick();
    check("seqA s1 q", 32'(bif.q), 32'hD2);
    check("seqA s1 busy", 32'(bif.busy), 32'(1));
    check("seqA s1 ready", 32'(bif.op_ready), 32'(0));
    check("seqA s1 done", 32'(bif.done), 32'(0));
    drive(1'b1, C_LOAD, 4'd0, 8'h00, 1'b1, 1'b0);
    tick();
    check("seqA s2 q", 32'(bif.q), 32'hE9);
    check("seqA s2 busy", 32'(bif.busy), 32'(1));
    check("seqA s2 done", 32'(bif.done), 32'(0));
    bif.op_valid = 1'b0;
    tick();
    check("seqA s3 q", 32'(bif.q), 32'hF4);
    check("seqA s3 busy", 32'(bif.busy), 32'(0));
    check("seqA s3 done", 32'(bif.done), 32'(1));
    tick();
    check("seqA after done", 32'(bif.done), 32'(0));
    check("seqA after q", 32'(bif.q), 32'hF4);

    // Full-width rotate returns the original value; oversized amount clamps.
    load(8'h3C);
    run_cmd(C_ROL, 4'd8, 1'b0, 1'b0, bc, de);
    check("rol8 q", 32'(bif.q), 32'h3C);
    check("rol8 busy cycles", 32'(bc), 32'(7));
    check("rol8 early done", 32'(de), 32'(0));
    check("rol8 done", 32'(bif.done), 32'(1));
    run_cmd(C_ROL, 4'd12, 1'b0, 1'b0, bc, de);
    check("rol12 q", 32'(bif.q), 32'h3C);
    check("rol12 busy cycles", 32'(bc), 32'(7));
    check("rol12 done", 32'(bif.done), 32'(1));

    // Arithmetic shift, then a zero-amount shift behaving like NOP.
    load(8'h90);
    run_cmd(C_ASR, 4'd2, 1'b0, 1'b0, bc, de);
    check("asr2 q", 32'(bif.q), 32'hE4);
    check("asr2 busy cycles", 32'(bc), 32'(1));
    check("asr2 done", 32'(bif.done), 32'(1));
    run_cmd(C_ASR, 4'd0, 1'b0, 1'b0, bc, de);
    check("asr0 q", 32'(bif.q), 32'hE4);
    check("asr0 busy cycles", 32'(bc), 32'(0));
    check("asr0 done", 32'(bif.done), 32'(1));

    // SHL by 5 aborted by asynchronous reset after two steps.
    load(8'h81);
    drive(1'b1, C_SHL, 4'd5, 8'h00, 1'b0, 1'b1);
    tick();
    bif.op_valid = 1'b0;
    tick();
    check("abort pre q", 32'(bif.q), 32'h07);
    check("abort pre busy", 32'(bif.busy), 32'(1));
    #2 reset = 1'b0;
    #1;
    check("abort q", 32'(bif.q), 32'h00);
    check("abort busy", 32'(bif.busy), 32'(0));
    check("abort ready", 32'(bif.op_ready), 32'(1));
    check("abort done", 32'(bif.done), 32'(0));
    tick();
    check("abort hold done", 32'(bif.done), 32'(0));
    reset = 1'b1;
    load(8'h5A);
    check("abort load q", 32'(bif.q), 32'h5A);
    check("abort load done", 32'(bif.done), 32'(1));
    check("abort load ready", 32'(bif.op_ready), 32'(1));

    mq = 8'h5A;
    random_phase();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
